// File: rtl/hammer_test_pkg.sv
// Shared types and address helpers for the row-hammer test engine.
package hammer_test_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    HAMMER = 3'd2,
    READ   = 3'd3,
    TALLY  = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SINGLE = 2'd0,
    DOUBLE = 2'd1,
    MANY   = 2'd2,
    RSVD   = 2'd3
  } mode_t;

  // Width of one tally lane for a given word width and lane count.
  function automatic int unsigned lane_width(int unsigned word_w, int unsigned lanes);
    return word_w / lanes;
  endfunction

  function automatic logic [63:0] field_mask(int unsigned pos, int unsigned width);
    logic [63:0] m;
    m = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return m << pos;
  endfunction

  function automatic logic [63:0] get_field(logic [63:0] v, int unsigned pos, int unsigned width);
    return (v & field_mask(pos, width)) >> pos;
  endfunction

  // Replace a field of base with val (val truncated to the field width).
  function automatic logic [63:0] set_field(logic [63:0] base, logic [63:0] val,
                                            int unsigned pos, int unsigned width);
    logic [63:0] m;
    m = field_mask(pos, width);
    return (base & ~m) | ((val << pos) & m);
  endfunction

  // Signed row offset of aggressor idx: SINGLE +1; DOUBLE -1,+1; MANY -1,+1,-3,+3,...
  function automatic int row_offset(mode_t m, int unsigned idx);
    int mag;
    case (m)
      MANY:    mag = 2 * int'(idx / 2) + 1;
      default: mag = 1;
    endcase
    if (m == SINGLE) return 1;
    return idx[0] ? mag : -mag;
  endfunction

endpackage

// File: rtl/hammer_aggr_seq.sv
// Aggressor address sequencer: walks the mode's row-offset table around the victim row.
module hammer_aggr_seq
  import hammer_test_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned ROW_WIDTH  = 12,
  parameter int unsigned ROW_POS    = 10,
  parameter int unsigned NUM_AGGR   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear,
  input  logic                  i_step,
  input  mode_t                 i_mode,
  input  logic [ADDR_WIDTH-1:0] i_victim,
  output logic [ADDR_WIDTH-1:0] o_aggr_addr
);

  localparam int unsigned IW = $clog2(NUM_AGGR);

  logic [IW-1:0]      r_idx;
  logic [31:0]        w_len;
  logic [63:0]        w_victim;
  logic [63:0]        w_row;
  logic signed [63:0] w_off;

  // Sequence length for the current mode.
  always_comb begin
    case (i_mode)
      SINGLE:  w_len = 32'd1;
      MANY:    w_len = 32'(NUM_AGGR);
      default: w_len = 32'd2;
    endcase
  end

  // Step through the table, wrapping back to the first entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_idx <= '0;
    else if (i_clear) r_idx <= '0;
    else if (i_step)  r_idx <= (32'(r_idx) + 32'd1 >= w_len) ? '0 : r_idx + 1'b1;
  end

  // Row field arithmetic wraps modulo 2^ROW_WIDTH; other address fields pass through.
  always_comb begin
    w_victim    = 64'(i_victim);
    w_off       = row_offset(i_mode, 32'(r_idx));
    w_row       = get_field(w_victim, ROW_POS, ROW_WIDTH) + w_off;
    o_aggr_addr = ADDR_WIDTH'(set_field(w_victim, w_row, ROW_POS, ROW_WIDTH));
  end

endmodule

// File: rtl/hammer_test_engine.sv
// Row-hammer test engine: fill victim row, hammer aggressors, read back, tally flipped bits.
// Optional macro HAMMER_FIRST_FLIP_LOG_EN adds first-flip address/mask capture outputs.
module hammer_test_engine
  import hammer_test_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned WORD_WIDTH = 64,
  parameter int unsigned ROW_WIDTH  = 12,
  parameter int unsigned ROW_POS    = 10,
  parameter int unsigned COL_WIDTH  = 10,
  parameter int unsigned COL_POS    = 0,
  parameter int unsigned NUM_AGGR   = 4,
  parameter int unsigned POP_LANES  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [WORD_WIDTH-1:0] pattern,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           count,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state,
  output logic [63:0]           bit_flip_count,
  output logic [COL_WIDTH:0]    flip_word_cnt
`ifdef HAMMER_FIRST_FLIP_LOG_EN
  ,
  output logic                  first_flip_vld,
  output logic [ADDR_WIDTH-1:0] first_flip_addr,
  output logic [WORD_WIDTH-1:0] first_flip_mask
`endif
);

  localparam int unsigned LANE_W = lane_width(WORD_WIDTH, POP_LANES);
  localparam int unsigned LIW    = (POP_LANES > 1) ? $clog2(POP_LANES) : 1;

  state_t                r_state;
  mode_t                 r_mode;
  logic [WORD_WIDTH-1:0] r_pattern, r_rdata;
  logic [ADDR_WIDTH-1:0] r_victim, r_maddr;
  logic [31:0]           r_count, r_hcnt;
  logic [COL_WIDTH-1:0]  r_col;
  logic [LIW-1:0]        r_lane;
  logic                  r_req, r_write, r_word_flip, r_abort_pend;
  logic [63:0]           r_bfc;
  logic [COL_WIDTH:0]    r_fwc;

  logic                  w_idle, w_go, w_proceed, w_ack, w_last_col, w_last_lane;
  logic [ADDR_WIDTH-1:0] w_aggr_addr, w_col_addr;
  logic [WORD_WIDTH-1:0] w_xor;
  logic [LANE_W-1:0]     w_lane_bits;
  logic [31:0]           w_pop;
  logic [64:0]           w_sum;

  assign w_idle      = (r_state == IDLE) || (r_state == DONE);
  assign w_go        = w_idle && start && !abort;
  assign w_proceed   = !abort && !r_abort_pend;
  assign w_ack       = r_req && mem_ack;
  assign w_last_col  = (r_col == '1);
  assign w_last_lane = (32'(r_lane) == POP_LANES - 1);
  assign w_col_addr  = ADDR_WIDTH'(set_field(64'(r_victim), 64'(r_col), COL_POS, COL_WIDTH));
  assign w_xor       = r_pattern ^ r_rdata;

  hammer_aggr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROW_WIDTH  (ROW_WIDTH),
    .ROW_POS    (ROW_POS),
    .NUM_AGGR   (NUM_AGGR)
  ) u_seq (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (w_go),
    .i_step      (w_ack && w_proceed && (r_state == HAMMER)),
    .i_mode      (r_mode),
    .i_victim    (r_victim),
    .o_aggr_addr (w_aggr_addr)
  );

  // Popcount of the current tally lane and the saturating running sum.
  always_comb begin
    w_lane_bits = LANE_W'(w_xor >> (32'(r_lane) * LANE_W));
    w_pop       = '0;
    for (int unsigned i = 0; i < LANE_W; i++) w_pop = w_pop + 32'(w_lane_bits[i]);
    w_sum = {1'b0, r_bfc} + 65'(w_pop);
  end

  // Main control: start/abort, request issue, ack handling and lane-by-lane tally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_mode       <= SINGLE;
      r_pattern    <= '0;
      r_rdata      <= '0;
      r_victim     <= '0;
      r_maddr      <= '0;
      r_count      <= '0;
      r_hcnt       <= '0;
      r_col        <= '0;
      r_lane       <= '0;
      r_req        <= 1'b0;
      r_write      <= 1'b0;
      r_word_flip  <= 1'b0;
      r_abort_pend <= 1'b0;
      r_bfc        <= '0;
      r_fwc        <= '0;
    end else if (w_idle) begin
      if (abort) begin
        r_state <= IDLE;
      end else if (start) begin
        r_mode    <= mode_t'(mode);
        r_pattern <= pattern;
        r_victim  <= address;
        r_count   <= count;
        r_col     <= '0;
        r_hcnt    <= '0;
        r_bfc     <= '0;
        r_fwc     <= '0;
        r_state   <= INIT;
      end
    end else if (!w_proceed) begin
      // An outstanding request must still see its ack before the engine can leave.
      if (!r_req || mem_ack) begin
        r_req        <= 1'b0;
        r_abort_pend <= 1'b0;
        r_state      <= IDLE;
      end else begin
        r_abort_pend <= 1'b1;
      end
    end else if (r_state == TALLY) begin
      r_bfc  <= w_sum[64] ? '1 : w_sum[63:0];
      r_lane <= r_lane + 1'b1;
      if (w_pop != '0) r_word_flip <= 1'b1;
      if (w_last_lane) begin
        if (r_word_flip || (w_pop != '0)) r_fwc <= r_fwc + 1'b1;
        r_col   <= r_col + 1'b1;
        r_state <= w_last_col ? DONE : READ;
      end
    end else if (!r_req) begin
      r_req   <= 1'b1;
      r_write <= (r_state == INIT);
      r_maddr <= (r_state == HAMMER) ? w_aggr_addr : w_col_addr;
    end else if (mem_ack) begin
      r_req <= 1'b0;
      case (r_state)
        INIT: begin
          r_col <= r_col + 1'b1;
          if (w_last_col) r_state <= (r_count == '0) ? READ : HAMMER;
        end
        HAMMER: begin
          r_hcnt <= r_hcnt + 32'd1;
          if (r_hcnt == r_count - 32'd1) r_state <= READ;
        end
        READ: begin
          r_rdata     <= mem_rdata;
          r_lane      <= '0;
          r_word_flip <= 1'b0;
          r_state     <= TALLY;
        end
        default: ;
      endcase
    end
  end

`ifdef HAMMER_FIRST_FLIP_LOG_EN
  logic                  r_ff_vld;
  logic [ADDR_WIDTH-1:0] r_ff_addr;
  logic [WORD_WIDTH-1:0] r_ff_mask;
  logic                  w_read_ack;

  assign w_read_ack = w_ack && w_proceed && (r_state == READ);

  // Capture the first victim word that reads back with any flipped bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ff_vld  <= 1'b0;
      r_ff_addr <= '0;
      r_ff_mask <= '0;
    end else if (w_go) begin
      r_ff_vld  <= 1'b0;
      r_ff_addr <= '0;
      r_ff_mask <= '0;
    end else if (w_read_ack && !r_ff_vld && ((mem_rdata ^ r_pattern) != '0)) begin
      r_ff_vld  <= 1'b1;
      r_ff_addr <= r_maddr;
      r_ff_mask <= mem_rdata ^ r_pattern;
    end
  end

  assign first_flip_vld  = r_ff_vld;
  assign first_flip_addr = r_ff_addr;
  assign first_flip_mask = r_ff_mask;
`else
  // First-flip capture not built.
`endif

  assign mem_req        = r_req;
  assign mem_write      = r_write;
  assign mem_addr       = r_maddr;
  assign mem_wdata      = r_pattern;
  assign busy           = !w_idle;
  assign done           = (r_state == DONE);
  assign state          = r_state;
  assign bit_flip_count = r_bfc;
  assign flip_word_cnt  = r_fwc;

endmodule

// File: tb/tb_hammer_test_engine.sv
// Directed bench for hammer_test_engine with an 8-column victim row and a latency-varying responder.
module tb_hammer_test_engine;

  logic        clk, reset_n, start, abort;
  logic [1:0]  mode;
  logic [63:0] pattern, address, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] count;
  logic        mem_req, mem_ack, mem_write, busy, done;
  logic [2:0]  state;
  logic [63:0] bit_flip_count;
  logic [3:0]  flip_word_cnt;

  typedef struct {
    logic [63:0] addr;
    logic        wr;
    logic [63:0] wdata;
  } txn_t;

  txn_t        log_q[$];
  logic [63:0] inj[8];
  logic [63:0] tb_pattern;
  logic [11:0] tb_vrow;
  int          lat_fixed;
  int          total, bad;

  hammer_test_engine #(.COL_WIDTH(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .pattern        (pattern),
    .address        (address),
    .count          (count),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .done           (done),
    .state          (state),
    .bit_flip_count (bit_flip_count),
    .flip_word_cnt  (flip_word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_col(logic [63:0] base, int c);
    return (base & ~64'h7) | 64'(c);
  endfunction

  function automatic logic [63:0] exp_row(logic [63:0] base, logic [11:0] row);
    return (base & ~(64'hFFF << 10)) | (64'(row) << 10);
  endfunction

  // Memory responder: acks each request after 0..3 cycles, logs it, checks it stayed stable.
  initial begin
    int          cnt;
    logic        pend;
    logic [63:0] a0;
    logic        w0;
    logic [2:0]  c;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    pend      = 1'b0;
    cnt       = 0;
    a0        = '0;
    w0        = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mem_ack = 1'b0;
        pend    = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!pend) begin
          pend = 1'b1;
          cnt  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
          a0   = mem_addr;
          w0   = mem_write;
        end
        if (cnt == 0) begin
          total++;
          if (mem_addr !== a0 || mem_write !== w0) begin
            bad++;
            $display("FAIL req_stable: addr=%h wr=%b required addr=%h wr=%b", mem_addr, mem_write, a0, w0);
          end
          c = mem_addr[2:0];
          if (!mem_write && mem_addr[21:10] == tb_vrow) mem_rdata = tb_pattern ^ inj[c];
          else mem_rdata = '0;
          log_q.push_back('{addr: mem_addr, wr: mem_write, wdata: mem_wdata});
          mem_ack = 1'b1;
          pend    = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic clear_inj();
    for (int i = 0; i < 8; i++) inj[i] = '0;
  endtask

  // Launch a test, then scramble the inputs to show they were captured at start.
  task automatic start_run(input logic [1:0] m, input logic [63:0] p, input logic [63:0] a,
                           input logic [31:0] c);
    log_q.delete();
    tb_pattern = p;
    tb_vrow    = a[21:10];
    @(negedge clk);
    mode = m; pattern = p; address = a; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pattern = ~p; address = a ^ 64'h0000_0000_003F_FC00; mode = ~m; count = c + 32'd5;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL wait_done: done=%b required 1 within %0d cycles", done, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; pattern = '0; address = '0; count = '0;
    lat_fixed = -1;
    clear_inj();
    tb_pattern = '0;
    tb_vrow = '0;
    repeat (3) @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL reset_ctl: req=%b busy=%b done=%b state=%0d required 0 0 0 0", mem_req, busy, done, state);
    end
    total++;
    if (bit_flip_count !== 64'd0 || flip_word_cnt !== 4'd0 || mem_addr !== 64'd0 ||
        mem_wdata !== 64'd0 || mem_write !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: bfc=%h fwc=%h addr=%h wdata=%h wr=%b required all 0",
               bit_flip_count, flip_word_cnt, mem_addr, mem_wdata, mem_write);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_double_no_flip();
    logic [63:0] base = (64'hA5 << 40) | (64'h123 << 10) | 64'h2AD;
    logic [63:0] p = 64'h0F0F_1234_5678_9ABC;
    logic [63:0] ea;
    logic        ew;
    clear_inj();
    start_run(2'd1, p, base, 32'd6);
    wait_done(3000);
    total++;
    if (log_q.size() !== 22) begin
      bad++;
      $display("FAIL double_len: got %0d transfers required 22", log_q.size());
    end else begin
      for (int i = 0; i < 22; i++) begin
        if (i < 8)       begin ea = exp_col(base, i); ew = 1'b1; end
        else if (i < 14) begin ea = exp_row(base, ((i - 8) % 2 == 1) ? 12'h124 : 12'h122); ew = 1'b0; end
        else             begin ea = exp_col(base, i - 14); ew = 1'b0; end
        total++;
        if (log_q[i].addr !== ea || log_q[i].wr !== ew) begin
          bad++;
          $display("FAIL double_txn[%0d]: addr=%h wr=%b required addr=%h wr=%b", i, log_q[i].addr, log_q[i].wr, ea, ew);
        end
        if (ew) begin
          total++;
          if (log_q[i].wdata !== p) begin
            bad++;
            $display("FAIL double_wdata[%0d]: got %h required %h", i, log_q[i].wdata, p);
          end
        end
      end
    end
    total++;
    if (bit_flip_count !== 64'd0 || flip_word_cnt !== 4'd0 || done !== 1'b1 || busy !== 1'b0 || state !== 3'd5) begin
      bad++;
      $display("FAIL double_result: bfc=%0d fwc=%0d done=%b busy=%b state=%0d required 0 0 1 0 5",
               bit_flip_count, flip_word_cnt, done, busy, state);
    end
  endtask

  task automatic test_flip_tally();
    logic [63:0] base = (64'h3 << 32) | (64'hFFF << 10);
    clear_inj();
    inj[5] = 64'h0000_0001_8000_0003;
    start_run(2'd0, 64'hDEAD_BEEF_0123_4567, base, 32'd3);
    wait_done(3000);
    total++;
    if (bit_flip_count !== 64'd4 || flip_word_cnt !== 4'd1) begin
      bad++;
      $display("FAIL flip_one_word: bfc=%0d fwc=%0d required 4 1", bit_flip_count, flip_word_cnt);
    end
    total++;
    if (log_q.size() !== 19) begin
      bad++;
      $display("FAIL single_len: got %0d transfers required 19", log_q.size());
    end else begin
      for (int i = 8; i < 11; i++) begin
        total++;
        if (log_q[i].addr !== exp_row(base, 12'h000) || log_q[i].wr !== 1'b0) begin
          bad++;
          $display("FAIL single_wrap[%0d]: addr=%h required %h", i, log_q[i].addr, exp_row(base, 12'h000));
        end
      end
    end
    clear_inj();
    inj[2] = 64'h0000_0000_0000_0001;
    inj[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    inj[7] = 64'h8000_0000_0000_0000;
    start_run(2'd1, 64'h5555_AAAA_0000_FFFF, base, 32'd2);
    wait_done(3000);
    total++;
    if (bit_flip_count !== 64'd66 || flip_word_cnt !== 4'd3) begin
      bad++;
      $display("FAIL flip_multi_word: bfc=%0d fwc=%0d required 66 3", bit_flip_count, flip_word_cnt);
    end
  endtask

  task automatic test_many_wrap();
    logic [63:0] base = 64'h0000_0077_0000_0000;
    logic [11:0] rows[4] = '{12'hFFF, 12'h001, 12'hFFD, 12'h003};
    clear_inj();
    start_run(2'd2, 64'h1111_2222_3333_4444, base, 32'd8);
    wait_done(3000);
    total++;
    if (log_q.size() !== 24) begin
      bad++;
      $display("FAIL many_len: got %0d transfers required 24", log_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (log_q[8 + i].addr !== exp_row(base, rows[i % 4]) || log_q[8 + i].wr !== 1'b0) begin
          bad++;
          $display("FAIL many_row[%0d]: addr=%h required %h", i, log_q[8 + i].addr, exp_row(base, rows[i % 4]));
        end
      end
    end
  endtask

  task automatic test_count_zero();
    logic [63:0] base = (64'h200 << 10) | 64'h5;
    clear_inj();
    start_run(2'd2, 64'hCAFE_F00D_1234_0000, base, 32'd0);
    wait_done(3000);
    total++;
    if (log_q.size() !== 16) begin
      bad++;
      $display("FAIL zero_len: got %0d transfers required 16", log_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (log_q[i].addr !== exp_col(base, i % 8) || log_q[i].wr !== (i < 8)) begin
          bad++;
          $display("FAIL zero_txn[%0d]: addr=%h wr=%b required addr=%h wr=%b", i, log_q[i].addr, log_q[i].wr,
                   exp_col(base, i % 8), (i < 8));
        end
      end
    end
  endtask

  task automatic test_abort_start_same_cycle();
    @(negedge clk);
    mode = 2'd1; pattern = 64'h1; address = '0; count = 32'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++;
    if (state !== 3'd0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL abort_wins: state=%0d busy=%b req=%b required 0 0 0", state, busy, mem_req);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort_hammer();
    int   n = 0;
    logic prev = 1'b1;
    int   sz;
    clear_inj();
    lat_fixed = 3;
    start_run(2'd1, 64'h0123_4567_89AB_CDEF, 64'h4000, 32'd100);
    while (!(state === 3'd2 && mem_req === 1'b1 && prev === 1'b0) && n < 500) begin
      prev = mem_req;
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL abort_reach_hammer: state=%0d req=%b required HAMMER request", state, mem_req);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (mem_req !== 1'b1 || busy !== 1'b1 || state !== 3'd2) begin
      bad++;
      $display("FAIL abort_hold_req: req=%b busy=%b state=%0d required 1 1 2", mem_req, busy, state);
    end
    n = 0;
    while (mem_ack !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    sz = log_q.size();
    @(negedge clk);
    total++;
    if (state !== 3'd0 || busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: state=%0d busy=%b req=%b done=%b required 0 0 0 0", state, busy, mem_req, done);
    end
    repeat (6) @(negedge clk);
    total++;
    if (log_q.size() !== sz || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet: transfers=%0d req=%b required %0d 0", log_q.size(), mem_req, sz);
    end
    lat_fixed = -1;
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    clear_inj();
    inj[0] = 64'hF;
    start_run(2'd1, 64'h8888_7777_6666_5555, 64'h0001_0000, 32'd0);
    while (!(bit_flip_count !== 64'd0 && state === 3'd3 && mem_req === 1'b1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL rst_reach_read: bfc=%0d state=%0d required nonzero in READ", bit_flip_count, state);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || state !== 3'd0 || bit_flip_count !== 64'd0 ||
        flip_word_cnt !== 4'd0 || mem_wdata !== 64'd0 || mem_addr !== 64'd0) begin
      bad++;
      $display("FAIL rst_async: req=%b busy=%b state=%0d bfc=%0d fwc=%0d wdata=%h addr=%h required all 0",
               mem_req, busy, state, bit_flip_count, flip_word_cnt, mem_wdata, mem_addr);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_inj();
    inj[6] = 64'h0000_0000_0000_0003;
    start_run(2'd0, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0002_0000, 32'd2);
    wait_done(3000);
    total++;
    if (bit_flip_count !== 64'd2 || flip_word_cnt !== 4'd1 || log_q.size() !== 18) begin
      bad++;
      $display("FAIL rst_rerun: bfc=%0d fwc=%0d transfers=%0d required 2 1 18",
               bit_flip_count, flip_word_cnt, log_q.size());
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_double_no_flip();
    test_flip_tally();
    test_many_wrap();
    test_count_zero();
    test_abort_start_same_cycle();
    test_abort_hammer();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
